bcd_counter_display: RTL

Parametrised multi-digit decimal counter with built-in seven-segment decoding. It replaces the per-digit combinational decoders driven by an external 4-bit counter. It counts 0..MAX_COUNT up or down on a prescaled tick and drives DIGITS active-low HEX displays directly from registered segment outputs. It sits between the board clock/switch inputs and the HEX pins in the top-level display path.

---
 rtl/bcd_counter_display.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_display.sv
// bcd_counter_display
//   Multi-digit BCD up/down counter with a prescaled step and registered
//   active-low seven-segment outputs for DIGITS HEX displays.
//   Optional feature macro: LEADING_ZERO_BLANK_EN. When defined, leading zero
//   digits above digit 0 are blanked (7F). When undefined, every digit is shown.
//
//   Output protocol: there is no valid/ready handshake. count, hex and wrap are
//   free-running registered values that are meaningful on every cycle. They
//   change only on a rising clk edge, or immediately when rst rises.
module bcd_counter_display #(
   parameter int DIGITS    = 2,
   parameter int MAX_COUNT = 10,
   parameter int TICK_DIV  = 50_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   count,
   output logic [7*DIGITS-1:0]   hex,
   output logic                  wrap
);

   localparam int CW    = 4 * DIGITS;
   localparam int HW    = 7 * DIGITS;
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   // Convert an integer to a packed BCD vector, digit 0 in the low nibble.
   function automatic logic [CW-1:0] to_bcd(input int value);
      logic [CW-1:0] r;
      int            v;
      r = '0;
      v = value;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Active-low segment pattern for one digit, bit 0 = a ... bit 6 = g.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;  // non-BCD codes are blanked
      endcase
      return s;
   endfunction

   // Decode a full BCD vector into the HEX bus, walking from the most
   // significant digit so leading zeros can be tracked when blanking is on.
   function automatic logic [HW-1:0] decode_all(input logic [CW-1:0] value);
      logic [HW-1:0] r;
      logic [3:0]    digit;
      logic [6:0]    seg;
`ifdef LEADING_ZERO_BLANK_EN
      logic          zero_run;
      zero_run = 1'b1;
`endif
      r = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         digit = value[4*k +: 4];
         seg   = seg7(digit);
`ifdef LEADING_ZERO_BLANK_EN
         zero_run = zero_run & (digit == 4'd0);
         if ((k > 0) && zero_run) begin
            seg = 7'h7F;
         end
`endif
         r[7*k +: 7] = seg;
      end
      return r;
   endfunction

   // BCD increment with ripple carry: a 9 rolls to 0 and carries upward.
   function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] value);
      logic [CW-1:0] r;
      logic          carry;
      r     = value;
      carry = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (carry) begin
            if (r[4*k +: 4] == 4'd9) begin
               r[4*k +: 4] = 4'd0;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // BCD decrement with borrow: a 0 rolls to 9 and borrows upward.
   function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] value);
      logic [CW-1:0] r;
      logic          borrow;
      r      = value;
      borrow = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            if (r[4*k +: 4] == 4'd0) begin
               r[4*k +: 4] = 4'd9;
            end else begin
               r[4*k +: 4] = r[4*k +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Terminal count as a full BCD vector; a count of 10 is not "all nines",
   // so the comparison must use every digit at once.
   localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);
   localparam logic [HW-1:0] HEX_RST = decode_all('0);

   logic [CW-1:0]    count_q, count_d;
   logic [HW-1:0]    hex_q, hex_d;
   logic             wrap_q, wrap_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;

   // One step per TICK_DIV enabled cycles; en low freezes the prescaler.
   assign tick = en && (pre_q == PRE_LAST);

   // Next prescaler, count and wrap; clear overrides any tick in the same cycle.
   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      if (clear) begin
         pre_d   = '0;
         count_d = '0;
      end else if (tick) begin
         pre_d = '0;
         if (up) begin
            if (count_q == MAX_BCD) begin
               count_d = '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = bcd_inc(count_q);
            end
         end else begin
            if (count_q == '0) begin
               count_d = MAX_BCD;
               wrap_d  = 1'b1;
            end else begin
               count_d = bcd_dec(count_q);
            end
         end
      end else if (en) begin
         pre_d = pre_q + 1'b1;
      end
   end

   // Segments come from the next-state count so hex and count move together.
   always_comb begin
      hex_d = decode_all(count_d);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q   <= '0;
         count_q <= '0;
         hex_q   <= HEX_RST;
         wrap_q  <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         count_q <= count_d;
         hex_q   <= hex_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign hex   = hex_q;
   assign wrap  = wrap_q;

endmodule
